rotl_seq: RTL
=============

// Module: rotl_seq
// PURPOSE
//  Multi-cycle left-rotate engine: the inverse direction of the team's 8-bit
//  combinational right-rotate barrel shifter. Undoes a right rotation by k bits,
//  one bit per cycle, using a small counter instead of a full mux tree.
//  Sits between a valid/ready producer and consumer on the data path. Holds
//  one operand at a time.
// PARAMETERS
//  W   8            data width in bits; must be a power of 2 and >= 2
//  AW  $clog2(W)    width of the rotate amount (derived; do not override)
// PORTS
//  clk        in   1    single clock; all state is updated on the rising edge
//  rst_n      in   1    asynchronous reset, active-low
//  in_valid   in   1    operand valid
//  in_ready   out  1    engine can accept; equals (state==IDLE)
//  in_data    in   W    value to rotate left
//  in_amt     in   AW   rotate-left amount, range 0..W-1
//  out_valid  out  1    result valid; equals (state==DONE)
//  out_ready  in   1    consumer accepts result
//  out_data   out  W    rotated result; held stable while out_valid=1
//  busy       out  1    state != IDLE
// BEHAVIOUR
//  Reset (async assert, sync release): state=IDLE, data_q=0, cnt_q=0;
//   in_ready=1, out_valid=0, out_data=0, busy=0. Asserting reset mid-operation
//   drops the operation; no output is produced for it.
//  FSM states are IDLE, SHIFT, DONE.
//   IDLE : in_valid&&in_ready -> latch data_q=in_data, cnt_q=in_amt; go SHIFT.
//   SHIFT: cnt_q==0 -> DONE; else data_q={data_q[W-2:0],data_q[W-1]},
//          cnt_q=cnt_q-1, stay in SHIFT.
//   DONE : out_ready -> IDLE; else hold. out_data=data_q, stable.
//  Latency: acceptance at edge E0 gives out_valid=1 after edge E0+k+1
//   (k=in_amt). Throughput is one operand per k+3 cycles at most (no overlap).
//  in_ready=0 in SHIFT and DONE. in_valid/in_data are ignored in those states.
//  The producer holds in_valid/in_data until the handshake completes.
//  A new operand is never accepted in the same cycle as the out handshake.
//  The first accept happens on the edge after DONE->IDLE.
//  Arithmetic: cnt_q is AW bits and only decrements from in_amt to 0, so it
//   never wraps. A full-width rotate (amt=W) cannot be expressed by in_amt.
//  Functional contract: out_data == rotl(in_data, in_amt). For every a and k,
//   rotl(rotr(a,k),k) == a, where rotr is the existing barrel shifter.
// CONFIGURATION
//  ROTL_ZERO_BYPASS_EN defined: in IDLE, on accept with in_amt==0, the engine
//   goes directly to DONE with data_q=in_data. Latency for k=0 is then 1
//   cycle; latency for k>0 is unchanged.
//  ROTL_ZERO_BYPASS_EN undefined: k=0 goes through SHIFT for one cycle.
//   Latency for k=0 is then 2 cycles.
// STRUCTURE
//  Shared package rotl_pkg: state encoding localparams (ST_IDLE=2'd0,
//   ST_SHIFT=2'd1, ST_DONE=2'd2), the default width constant ROT_W=8, and a
//   function rotl_ref(a,k) for use by the bench.
//  Sub-module rotl1_step (combinational 1-bit left rotate, W-parameterised) is
//   the natural split. The FSM, counter and data register stay in rotl_seq.
// TESTING
//  1 Reset: assert rst_n=0 mid-SHIFT -> out_valid=0, in_ready=1, out_data=0
//    immediately (async); after release the next op works.
//  2 in_data=8'hB1, in_amt=3 -> out_data=8'h8D; out_valid rises 4 edges after
//    accept.
//  3 Inverse check: for all a in 0..255 and k in 0..7, feed rotr(a,k) with
//    amt=k -> out_data==a.
//  4 k=0, in_data=8'h5A -> out_data=8'h5A. Latency is 2 cycles, or 1 with
//    ROTL_ZERO_BYPASS_EN defined.
//  5 Backpressure: out_ready=0 for 5 cycles in DONE -> out_data stable and
//    in_ready=0 for all 5; a pending in_valid is accepted only after the out
//    handshake.
//  6 k=7, in_data=8'h01 -> out_data=8'h80 after 8 cycles; back-to-back ops
//    with in_valid held high -> no lost or duplicated results.

Source files
------------

// File: rtl/rotl_pkg.sv
// Shared definitions for the multi-cycle left-rotate engine: FSM state
// encoding, default data width, and a reference rotate-left function.
package rotl_pkg;

    localparam int ROT_W = 8;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    // Rotate a ROT_W-bit value left by k positions (k taken modulo ROT_W).
    function automatic logic [ROT_W-1:0] rotl_ref(
        input logic [ROT_W-1:0] a,
        input int unsigned      k
    );
        logic [ROT_W-1:0] r;
        r = a;
        for (int unsigned i = 0; i < (k % ROT_W); i++) begin
            r = {r[ROT_W-2:0], r[ROT_W-1]};
        end
        return r;
    endfunction

endpackage

// File: rtl/rotl1_step.sv
// Combinational single-position left rotate.
// Ports: a (W-bit operand in), y (a rotated left by one, out).
module rotl1_step #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    output logic [W-1:0] y
);

    assign y = {a[W-2:0], a[W-1]};

endmodule

// File: rtl/rotl_seq.sv
// Multi-cycle left-rotate engine: rotates one operand left by in_amt bits,
// one bit per cycle, between a valid/ready producer and consumer.
// Ports: clk, rst_n (async, active-low); in_valid/in_ready/in_data/in_amt
// (operand side); out_valid/out_ready/out_data (result side); busy.
// Optional macro ROTL_ZERO_BYPASS_EN: a zero rotate amount skips SHIFT
// and goes straight to DONE on accept.
module rotl_seq
    import rotl_pkg::*;
#(
    parameter int W  = ROT_W,
    parameter int AW = $clog2(W)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_data,
    input  logic [AW-1:0] in_amt,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_data,
    output logic          busy
);

    logic [1:0]    state_q, state_d;
    logic [W-1:0]  data_q, data_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  data_rot;
    logic          accept;

    rotl1_step #(
        .W (W)
    ) u_step (
        .a (data_q),
        .y (data_rot)
    );

    assign accept = in_valid && (state_q == ST_IDLE);

    // State, data and counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
`ifdef ROTL_ZERO_BYPASS_EN
                    state_d = (in_amt == '0) ? ST_DONE : ST_SHIFT;
`else
                    state_d = ST_SHIFT;
`endif
                end
            end
            ST_SHIFT: begin
                if (cnt_q == '0) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath: load on accept, one rotate step per SHIFT cycle.
    // The counter only counts down to zero, so it never wraps.
    always_comb begin
        data_d = data_q;
        cnt_d  = cnt_q;
        if (accept) begin
            data_d = in_data;
            cnt_d  = in_amt;
        end else if ((state_q == ST_SHIFT) && (cnt_q != '0)) begin
            data_d = data_rot;
            cnt_d  = cnt_q - AW'(1);
        end
    end

    // Outputs
    always_comb begin
        in_ready  = (state_q == ST_IDLE);
        out_valid = (state_q == ST_DONE);
        busy      = (state_q != ST_IDLE);
        out_data  = data_q;
    end

endmodule
